// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, the result flag
// bundle, and the flag pattern reported for an illegal opcode.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_INC  = 4'h3,
    OP_DEC  = 4'h4,
    OP_OR   = 4'h5,
    OP_AND  = 4'h6,
    OP_XOR  = 4'h7,
    OP_SHR  = 4'h8,
    OP_SHL  = 4'h9,
    OP_NOT  = 4'hA,
    OP_NEG  = 4'hB,
    OP_ADC  = 4'hC,
    OP_SBB  = 4'hD,
    OP_ROL  = 4'hE,
    OP_ROR  = 4'hF
  } opcode_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
    logic err;
  } flags_t;

  // An illegal opcode yields a zero result, so zero is set and err flags it.
  localparam flags_t ILLEGAL_FLAGS = '{zero: 1'b1, carry: 1'b0, neg: 1'b0,
                                       ovf: 1'b0, err: 1'b1};

  localparam flags_t CLEAR_FLAGS = '{zero: 1'b0, carry: 1'b0, neg: 1'b0,
                                     ovf: 1'b0, err: 1'b0};

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus of the sequential ALU. The master drives operands and
// accepts results; the slave is the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 8
);

  logic             carry_clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_neg;
  logic             alu_ovf;
  logic             alu_err;

  modport master (
    output carry_clr, in_valid, in_a, in_b, opcode, out_ready,
    input  in_ready, out_valid, alu_out, alu_zero, alu_carry, alu_neg,
           alu_ovf, alu_err
  );

  modport slave (
    input  carry_clr, in_valid, in_a, in_b, opcode, out_ready,
    output in_ready, out_valid, alu_out, alu_zero, alu_carry, alu_neg,
           alu_ovf, alu_err
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, opcode, cin) -> result + flags.
// Rotate-through-carry opcodes exist only when ALU_SEQ_ROTATE_EN is defined;
// otherwise 0xE/0xF decode as illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] ext;
  logic           carry;
  logic           ovf;
  logic           illegal;

  // Signed overflow of x + y giving r: like-signed operands, result sign flips.
  function automatic logic add_ovf(input logic [WIDTH-1:0] x, y, r);
    return (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]);
  endfunction

  // Signed overflow of x - y giving r: unlike-signed operands, result sign
  // differs from the minuend.
  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, y, r);
    return (x[MSB] != y[MSB]) && (r[MSB] != x[MSB]);
  endfunction

  // Decode the opcode into a raw result, carry/borrow and overflow.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    ext     = '0;
    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    unique case (opcode_e'(opcode))
      OP_PASS: result = a;
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[MSB:0];
        carry  = ext[WIDTH];
        ovf    = add_ovf(a, b, result);
      end
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[MSB:0];
        carry  = ext[WIDTH];
        ovf    = sub_ovf(a, b, result);
      end
      OP_INC: begin
        ext    = {1'b0, a} + {1'b0, ONE};
        result = ext[MSB:0];
        carry  = ext[WIDTH];
        ovf    = add_ovf(a, ONE, result);
      end
      OP_DEC: begin
        ext    = {1'b0, a} - {1'b0, ONE};
        result = ext[MSB:0];
        carry  = (a == '0);
        ovf    = sub_ovf(a, ONE, result);
      end
      OP_OR:  result = a | b;
      OP_AND: result = a & b;
      OP_XOR: result = a ^ b;
      OP_SHR: begin
        result = {1'b0, a[MSB:1]};
        carry  = a[0];
      end
      OP_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        carry  = a[MSB];
      end
      OP_NOT: result = ~a;
      OP_NEG: begin
        result = '0 - a;
        carry  = (a != '0);
        ovf    = (a == MIN_NEG);
      end
      OP_ADC: begin
        ext    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        result = ext[MSB:0];
        carry  = ext[WIDTH];
        ovf    = add_ovf(a, b, result);
      end
      OP_SBB: begin
        // Borrow lands in the extra top bit of the two's-complement difference.
        ext    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        result = ext[MSB:0];
        carry  = ext[WIDTH];
        ovf    = sub_ovf(a, b, result);
      end
`ifdef ALU_SEQ_ROTATE_EN
      OP_ROL: begin
        result = {a[MSB-1:0], cin};
        carry  = a[MSB];
      end
      OP_ROR: begin
        result = {cin, a[MSB:1]};
        carry  = a[0];
      end
`else
      OP_ROL, OP_ROR: illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

  // Package the flags; an illegal opcode overrides everything with a zero result.
  always_comb begin
    flags = CLEAR_FLAGS;
    if (illegal) begin
      flags = ILLEGAL_FLAGS;
    end else begin
      flags.zero  = (result == '0);
      flags.carry = carry;
      flags.neg   = result[MSB];
      flags.ovf   = ovf;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides and a persistent carry flag
// for multi-word arithmetic. Optional macro ALU_SEQ_ROTATE_EN enables the
// rotate-through-carry opcodes 0xE/0xF in alu_core.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);

  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;
  logic [WIDTH-1:0] out_q;
  flags_t           flags_q;
  logic             out_valid_q;
  logic             carry_q;
  logic             cin;
  logic             in_ready;
  logic             accept;

  // A pending carry_clr forces the incoming carry to zero in the same cycle.
  assign cin      = carry_q & ~bus.carry_clr;
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .opcode (bus.opcode),
    .cin    (cin),
    .result (core_result),
    .flags  (core_flags)
  );

  // Output register, valid flag and stored carry.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before this edge, independent of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= CLEAR_FLAGS;
      carry_q     <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_q       <= core_result;
        flags_q     <= core_flags;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // An illegal op never disturbs the stored carry; carry_clr still clears.
      if (accept && !core_flags.err) begin
        carry_q <= core_flags.carry;
      end else if (bus.carry_clr) begin
        carry_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = out_q;
  assign bus.alu_zero  = flags_q.zero;
  assign bus.alu_carry = flags_q.carry;
  assign bus.alu_neg   = flags_q.neg;
  assign bus.alu_ovf   = flags_q.ovf;
  assign bus.alu_err   = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH = 8. Expected flags are
// written as {zero, carry, neg, ovf, err}.
module tb_alu_seq;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operation for exactly one accepting edge, then sample.
  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic clr);
    bus.opcode    = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.carry_clr = clr;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.carry_clr = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [7:0] out, input logic [4:0] fl);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".out"}, 32'(bus.alu_out), 32'(out));
    check({tag, ".flags"},
          32'({bus.alu_zero, bus.alu_carry, bus.alu_neg, bus.alu_ovf, bus.alu_err}),
          32'(fl));
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.opcode    = '0;
    bus.carry_clr = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.out", 32'(bus.alu_out), 32'd0);
    check("rst.flags", 32'({bus.alu_zero, bus.alu_carry, bus.alu_neg, bus.alu_ovf,
                            bus.alu_err}), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Basic arithmetic, visible one edge after accept
    apply(4'h1, 8'hFF, 8'h01, 1'b0); expect_res("add_wrap", 8'h00, 5'b11000);

    // Carry chain, then the same chain with carry_clr on the ADC
    apply(4'h1, 8'hF0, 8'h20, 1'b0); expect_res("chain_add", 8'h10, 5'b01000);
    apply(4'hC, 8'h00, 8'h00, 1'b0); expect_res("chain_adc", 8'h01, 5'b00000);
    apply(4'h1, 8'hF0, 8'h20, 1'b0); expect_res("chain_add2", 8'h10, 5'b01000);
    apply(4'hC, 8'h00, 8'h00, 1'b1); expect_res("adc_clr", 8'h00, 5'b10000);

    // Flags on signed/unsigned boundaries
    apply(4'h2, 8'h05, 8'h06, 1'b0); expect_res("sub_borrow", 8'hFF, 5'b01100);
    apply(4'h1, 8'h7F, 8'h01, 1'b0); expect_res("add_ovf", 8'h80, 5'b00110);
    apply(4'hB, 8'h80, 8'h00, 1'b0); expect_res("neg_min", 8'h80, 5'b01110);
    apply(4'h3, 8'h7F, 8'h00, 1'b0); expect_res("inc_ovf", 8'h80, 5'b00110);
    apply(4'h3, 8'hFF, 8'h00, 1'b0); expect_res("inc_wrap", 8'h00, 5'b11000);
    apply(4'h4, 8'h00, 8'h00, 1'b0); expect_res("dec_zero", 8'hFF, 5'b01100);
    apply(4'h4, 8'h80, 8'h00, 1'b0); expect_res("dec_ovf", 8'h7F, 5'b00010);

    // Bitwise and shifts
    apply(4'h5, 8'h0F, 8'h30, 1'b0); expect_res("or", 8'h3F, 5'b00000);
    apply(4'h6, 8'h0F, 8'h3C, 1'b0); expect_res("and", 8'h0C, 5'b00000);
    apply(4'h7, 8'hFF, 8'h0F, 1'b0); expect_res("xor", 8'hF0, 5'b00100);
    apply(4'h8, 8'h03, 8'h00, 1'b0); expect_res("shr", 8'h01, 5'b01000);
    apply(4'h9, 8'h81, 8'h00, 1'b0); expect_res("shl", 8'h02, 5'b01000);
    apply(4'hA, 8'h5A, 8'h00, 1'b0); expect_res("not", 8'hA5, 5'b00100);
    apply(4'h0, 8'h00, 8'h33, 1'b0); expect_res("pass", 8'h00, 5'b10000);

    // Subtract with borrow chained from a SUB borrow: 0x10 - 0x05 - 1
    apply(4'h2, 8'h05, 8'h06, 1'b0); expect_res("sbb_pre", 8'hFF, 5'b01100);
    apply(4'hD, 8'h10, 8'h05, 1'b0); expect_res("sbb", 8'h0A, 5'b00000);

    // carry_clr with no accept clears the stored carry
    apply(4'h1, 8'hFF, 8'h01, 1'b0); expect_res("clr_pre", 8'h00, 5'b11000);
    bus.carry_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.carry_clr = 1'b0;
    check("drain.valid", 32'(bus.out_valid), 32'd0);
    apply(4'hC, 8'h00, 8'h00, 1'b0); expect_res("clr_idle_adc", 8'h00, 5'b10000);

    // Backpressure: result held, stored carry frozen, no loss or duplication
    apply(4'h1, 8'hFF, 8'h01, 1'b0); expect_res("bp_pre", 8'h00, 5'b11000);
    bus.out_ready = 1'b0;
    bus.opcode    = 4'hC;
    bus.in_a      = 8'h01;
    bus.in_b      = 8'h02;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      expect_res("bp.hold", 8'h00, 5'b11000);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_res("bp.adc", 8'h04, 5'b00000);
    bus.opcode = 4'h1;
    bus.in_a   = 8'h10;
    bus.in_b   = 8'h20;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expect_res("bp.next", 8'h30, 5'b00000);
    @(posedge clk);
    #1;
    check("bp.drain", 32'(bus.out_valid), 32'd0);

    // Opcode 0xE with stored carry = 1
    apply(4'h1, 8'hFF, 8'h01, 1'b0); expect_res("e_pre", 8'h00, 5'b11000);
    apply(4'hE, 8'h81, 8'h00, 1'b0);
`ifdef ALU_SEQ_ROTATE_EN
    expect_res("rol", 8'h03, 5'b01000);
`else
    expect_res("op_e_illegal", 8'h00, 5'b10001);
`endif
    apply(4'hC, 8'h00, 8'h00, 1'b0); expect_res("e_post_adc", 8'h01, 5'b00000);

    // Reset while a result is held drops it and clears the stored carry
    apply(4'h1, 8'hFF, 8'h01, 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check("midrst.valid", 32'(bus.out_valid), 32'd0);
    check("midrst.out", 32'(bus.alu_out), 32'd0);
    apply(4'hC, 8'h00, 8'h00, 1'b0); expect_res("midrst.adc", 8'h00, 5'b10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
